// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_pkg
//  Purpose  : Shared types and constants for the instruction memory loader.
//             - state_e       : controller state (RUN / CLEAR / LOAD)
//             - IMEM_NOP_INSTR: addi x0,x0,0, returned on faulting fetches
//             - clog2_words() : address width for a word-addressed memory
//  Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam logic [31:0] IMEM_NOP_INSTR = 32'h0000_0013;

    // Smallest w such that 2**w >= words (words in 2..65536).
    function automatic int clog2_words(input int words);
        int w;
        w = 0;
        for (int i = 0; i < 17; i++) begin
            if ((1 << i) < words) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_loader_if
//  Purpose  : Fetch and loader handshake bundle for instr_mem_loader.
//  Ports    : fetch_req/fetch_addr -> fetch_ready, instr_valid/instr/instr_err
//             ld_start/ld_valid/ld_data/ld_last -> ld_ready/ld_done/
//             ld_overflow, busy
//             master = core + loader side, slave = memory side
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_err;

    logic                  ld_start;
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  ld_done;
    logic                  ld_overflow;
    logic                  busy;

    modport master (
        output fetch_req, fetch_addr, ld_start, ld_valid, ld_data, ld_last,
        input  fetch_ready, instr_valid, instr, instr_err,
               ld_ready, ld_done, ld_overflow, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, ld_start, ld_valid, ld_data, ld_last,
        output fetch_ready, instr_valid, instr, instr_err,
               ld_ready, ld_done, ld_overflow, busy
    );

endinterface
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module   : imem_ram
//  Purpose  : Single-port synchronous RAM, DATA_WIDTH x DEPTH, registered
//             read data. Write has priority; rdata only changes on a read,
//             so it holds the last fetched word otherwise.
//  Ports    : clk, we, re, addr, wdata -> rdata
//  Revision : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int AW         = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset on the array or read register so the tools map it to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_loader
//  Purpose  : Instruction memory with one-cycle fetch and a run-time
//             clear+reload port. Faulting fetches (misaligned or beyond
//             MEM_SIZE words) return NOP_INSTR with instr_err set.
//  Ports    : clk, rst_n (async active-low)
//             bus (slave): fetch_req/fetch_addr/fetch_ready,
//                          instr_valid/instr/instr_err,
//                          ld_start/ld_valid/ld_data/ld_last/ld_ready,
//                          ld_done/ld_overflow/busy
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import imem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_SIZE   = 512,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(IMEM_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_mem_loader_if.slave  bus
);

    localparam int AW = clog2_words(MEM_SIZE);
    localparam int PW = AW + 1;              // ptr can hold MEM_SIZE itself
    localparam int IW = ADDR_WIDTH - 2;      // full word-index width
    localparam logic [PW-1:0] PTR_FULL  = PW'(MEM_SIZE);
    localparam logic [PW-1:0] PTR_LAST  = PW'(MEM_SIZE - 1);
    localparam logic [IW-1:0] IDX_LIMIT = IW'(MEM_SIZE);

    state_e                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  instr_err_q, instr_err_d;
    logic                  from_ram_q, from_ram_d;
    logic                  ld_done_q, ld_done_d;
    logic                  ld_overflow_q, ld_overflow_d;

    logic [IW-1:0]         w_idx;
    logic                  w_fetch_ok;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [AW-1:0]         w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Whole index is compared so high address bits never alias into the RAM.
    assign w_idx      = bus.fetch_addr[ADDR_WIDTH-1:2];
    assign w_fetch_ok = (bus.fetch_addr[1:0] == 2'b00) && (w_idx < IDX_LIMIT);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        instr_valid_d = 1'b0;
        instr_err_d   = instr_err_q;
        from_ram_d    = from_ram_q;
        ld_done_d     = 1'b0;
        ld_overflow_d = ld_overflow_q;
        w_ram_we      = 1'b0;
        w_ram_re      = 1'b0;
        w_ram_addr    = w_idx[AW-1:0];
        w_ram_wdata   = '0;

        case (state_q)
            ST_RUN: begin
                // A fetch accepted alongside ld_start is still served.
                if (bus.fetch_req) begin
                    instr_valid_d = 1'b1;
                    instr_err_d   = !w_fetch_ok;
                    from_ram_d    = w_fetch_ok;
                    w_ram_re      = w_fetch_ok;
                end
                if (bus.ld_start) begin
                    state_d       = ST_CLEAR;
                    ptr_d         = '0;
                    ld_overflow_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                w_ram_we   = 1'b1;
                w_ram_addr = ptr_q[AW-1:0];
                if (ptr_q == PTR_LAST) begin
                    ptr_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
            end
            ST_LOAD: begin
                w_ram_addr  = ptr_q[AW-1:0];
                w_ram_wdata = bus.ld_data;
                if (bus.ld_valid) begin
                    if (ptr_q < PTR_FULL) begin
                        w_ram_we = 1'b1;
                        ptr_d    = ptr_q + PW'(1);
                    end else begin
                        ld_overflow_d = 1'b1;
                    end
                    if (bus.ld_last) begin
                        ld_done_d = 1'b1;
                        state_d   = ST_RUN;
                        ptr_d     = '0;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            ptr_q         <= '0;
            instr_valid_q <= 1'b0;
            instr_err_q   <= 1'b0;
            from_ram_q    <= 1'b0;
            ld_done_q     <= 1'b0;
            ld_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            instr_valid_q <= instr_valid_d;
            instr_err_q   <= instr_err_d;
            from_ram_q    <= from_ram_d;
            ld_done_q     <= ld_done_d;
            ld_overflow_q <= ld_overflow_d;
        end
    end

    imem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_SIZE),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .re    (w_ram_re),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    // RAM rdata holds across idle cycles; from_ram_q picks it or the NOP.
    assign bus.instr       = from_ram_q ? w_ram_rdata : NOP_INSTR;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_err   = instr_err_q;
    assign bus.fetch_ready = (state_q == ST_RUN);
    assign bus.ld_ready    = (state_q == ST_LOAD);
    assign bus.busy        = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
    assign bus.ld_done     = ld_done_q;
    assign bus.ld_overflow = ld_overflow_q;

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Next-generation instruction memory for the pipelined RV32I core.
- Replaces the hardcoded, combinational-read ROM with a parametrised synchronous-read RAM.
- Fetch side uses a one-cycle-latency req/valid handshake; a streaming loader port (UART/debug bridge) clears and reprograms the RAM at run time while the core is stalled.
- Out-of-range and misaligned fetches are flagged and return a NOP.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, byte-address width of fetch_addr
MEM_SIZE, 512, depth in words; power of two, 2..65536
NOP_INSTR, 32'h00000013, word returned on faulting fetch (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request; sampled only when fetch_ready=1
fetch_addr  in  ADDR_WIDTH  byte address of requested instruction
fetch_ready  out  1  high only in RUN state
instr_valid  out  1  instr/instr_err valid this cycle
instr  out  DATA_WIDTH  fetched instruction
instr_err  out  1  fetch was misaligned or out of range
ld_start  in  1  one-cycle pulse: begin clear+load sequence
ld_valid  in  1  loader word valid
ld_data  in  DATA_WIDTH  loader word
ld_last  in  1  qualifies final loader word
ld_ready  out  1  high only in LOAD state
ld_done  out  1  one-cycle pulse when load completes
ld_overflow  out  1  sticky: words offered beyond MEM_SIZE were dropped
busy  out  1  high in CLEAR or LOAD; core stalls its PC on this

Behaviour:
- Reset (async assert, sync deassert):
  - state=RUN, ptr=0.
  - instr_valid=0, instr=NOP_INSTR, instr_err=0.
  - ld_done=0, ld_overflow=0.
  - RAM contents are not reset.
- States and transitions:
  - RUN: on ld_start -> CLEAR.
  - CLEAR: on ptr==MEM_SIZE-1 -> LOAD.
  - LOAD: on accepted beat with ld_last -> RUN.
- Fetch, legal when fetch_addr[1:0]==0 and word index fetch_addr[ADDR_WIDTH-1:2] < MEM_SIZE:
  - Accepted in RUN when fetch_req=1.
  - Next cycle: instr_valid=1, instr=RAM[index], instr_err=0.
  - Back-to-back requests sustain one fetch per cycle.
- Faulting fetch (misaligned or out of range): next cycle instr_valid=1, instr=NOP_INSTR, instr_err=1; RAM is not read.
- No accepted request: instr_valid=0 next cycle; instr and instr_err hold their last values.
- Fetch fetch_addr comparison uses the full index width; no aliasing/wrap of high bits.
- CLEAR:
  - Writes 0 to RAM[ptr], one word per cycle; ptr increments.
  - On ptr==MEM_SIZE-1: write, then ptr=0, go to LOAD.
  - Total MEM_SIZE cycles.
  - ld_overflow cleared on entry.
- LOAD:
  - A beat is accepted when ld_valid & ld_ready.
  - If ptr<MEM_SIZE, write RAM[ptr]=ld_data and ptr++. ptr is log2(MEM_SIZE)+1 bits wide and saturates at MEM_SIZE.
  - Otherwise drop the word and set ld_overflow.
  - Accepted beat with ld_last=1 (written or dropped): ld_done=1 next cycle for one cycle; state=RUN; ptr=0.
  - An empty load is impossible: ld_last must ride on a beat.
- ld_start in CLEAR or LOAD is ignored.
- Same cycle in RUN, fetch_req=1 and ld_start=1: fetch is served (valid next cycle); state moves to CLEAR.
- In CLEAR and LOAD: fetch_ready=0 and fetch_req is ignored. instr_valid deasserts from the first cycle after leaving RUN, except for the single in-flight fetch accepted in the transition cycle.
- Reset mid-CLEAR or mid-LOAD: return to RUN immediately. Partial contents are retained; no ld_done.
- RAM port use: one write or one read per cycle, never both, because state is exclusive. Read-during-write cannot occur.

Decomposition:
- Shared package imem_pkg:
  - state enum {RUN, CLEAR, LOAD}.
  - NOP_INSTR constant.
  - function clog2_words(MEM_SIZE) for ptr/index widths.
- Sub-module imem_ram: single-port synchronous RAM (DATA_WIDTH x MEM_SIZE, we, addr, wdata, registered rdata). Written so it infers block RAM.
- The FSM, fetch-fault check and loader pointer stay in instr_mem_loader.

Test Plan:
1. Reset, then a CLEAR+LOAD of 4 words {0x02000117, 0x04010113, 0x02000197, 0x7F818193} (last with ld_last). Then fetch addr 0x0,0x4,0x8,0xC back-to-back. Expect instr_valid 1 on 4 consecutive cycles with those words, instr_err=0, one fetch per cycle.
2. ld_start in RUN. Expect busy=1 for exactly MEM_SIZE+load cycles, ld_ready rising on cycle MEM_SIZE+1. Load 2 words, then fetch 0x8. Expect 0x00000000 (cleared) and ld_done pulse exactly one cycle after the last beat.
3. Fetch 0x802 (misaligned) and 0x800 with MEM_SIZE=512 (index 512, out of range). Expect instr=0x00000013, instr_err=1 each, RAM untouched.
4. MEM_SIZE=4: load 6 words, last on word 6. Expect words 1-4 stored, ld_overflow=1, ld_done pulse, fetch 0xC returns word 4.
5. fetch_req and ld_start in the same cycle. Expect the fetch result valid next cycle. Then fetch_ready=0 and ld_start during LOAD ignored: busy/ptr unaffected, no restart of CLEAR.
6. Assert rst_n=0 after 2 accepted load beats. Expect state RUN, busy=0 asynchronously, no ld_done, and fetch 0x0/0x4 returning the 2 loaded words.
